// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- pipeline-control bundle between the 4-stage CPU datapath
// and its hazard/sequencing controller.
//
// Signals (slave = controller side):
//   id_*      in   instruction in ID: valid, rs/rt indices and use flags,
//                  taken redirect, memory-indirect jump
//   ex_*      in   EX/MEM stage: valid, destination, register-write flag
//   wb_*      in   WB stage: valid, destination, register-write flag
//   pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel_mem
//             out  pipeline register / PC mux controls
//   state     out  controller FSM state (RUN=0, STALL=1, JMEM=2)
//   stall_cnt, flush_cnt
//             out  saturating statistics counters
//   wdog_err  out  sticky consecutive-stall watchdog flag
interface hazard_ctrl_if #(
  parameter int REG_AW = 6,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_redirect;
  logic              id_jump_mem;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              pc_sel_mem;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              wdog_err;

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_redirect, id_jump_mem,
    input  ex_valid, ex_rd, ex_regwrite, wb_valid, wb_rd, wb_regwrite,
    output pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel_mem,
    output state, stall_cnt, flush_cnt, wdog_err
  );

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_redirect, id_jump_mem,
    output ex_valid, ex_rd, ex_regwrite, wb_valid, wb_rd, wb_regwrite,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel_mem,
    input  state, stall_cnt, flush_cnt, wdog_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the 4-stage CPU
// (IF, ID, EX/MEM, WB).
//
// Stalls PC and IF/ID and bubbles ID/EX on read-after-write hazards against
// EX/MEM and WB (no register-file write-through, so WB conflicts stall too),
// squashes IF/ID on taken redirects, and runs the two-cycle memory-indirect
// jump whose target comes from data memory in EX/MEM. Keeps saturating
// stall/flush counters and a sticky consecutive-stall watchdog.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    hazard_ctrl_if.slave -- stage inputs, pipeline controls, status
module hazard_ctrl #(
  parameter int REG_AW    = 6,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    JMEM  = 2'd2
  } state_e;

  // Consecutive-stall counter only needs to reach MAX_STALL; it saturates there.
  localparam int CW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_STALL);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]    consec_q, consec_d;
  logic             wdog_q, wdog_d;

  // ---------------------------------------------------------------------
  // RAW hazard detection: index 0 = EX/MEM, index 1 = WB.
  // ---------------------------------------------------------------------
  logic [REG_AW-1:0] dst_rd [2];
  logic [1:0]        dst_valid;
  logic [1:0]        dst_we;
  logic [1:0]        raw;
  logic              hazard;

  assign dst_rd[0]    = bus.ex_rd;
  assign dst_rd[1]    = bus.wb_rd;
  assign dst_valid[0] = bus.ex_valid;
  assign dst_valid[1] = bus.wb_valid;
  assign dst_we[0]    = bus.ex_regwrite;
  assign dst_we[1]    = bus.wb_regwrite;

  for (genvar gi = 0; gi < 2; gi++) begin : g_raw
    assign raw[gi] = bus.id_valid & dst_valid[gi] & dst_we[gi] &
                     ((bus.id_use_rs & (bus.id_rs == dst_rd[gi])) |
                      (bus.id_use_rt & (bus.id_rt == dst_rd[gi])));
  end

  assign hazard = |raw;

  // ---------------------------------------------------------------------
  // Control decode. STALL is decoded exactly like RUN: the first hazard-free
  // cycle after a stall already behaves as RUN, so a redirect waiting in ID
  // is accepted without an extra cycle.
  // ---------------------------------------------------------------------
  logic pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel_mem;
  logic count_flush;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_sel_mem  = 1'b0;
    count_flush = 1'b0;
    state_d     = RUN;

    if (state_q == JMEM) begin
      // ID holds the bubble inserted on entry, so no hazard check here. The
      // flush for this sequence was already counted on the entry cycle.
      pc_sel_mem  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      // Redirects are ignored while stalled; they are retried once the
      // operands are available.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = STALL;
    end else if (bus.id_jump_mem) begin
      // The jump itself proceeds into EX/MEM to read its target; hold the PC
      // until the data-memory output is available next cycle.
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      count_flush = 1'b1;
      state_d     = JMEM;
    end else if (bus.id_redirect) begin
      ifid_flush  = 1'b1;
      count_flush = 1'b1;
    end

    // While reset is held the pipeline free-runs with no bubbles or flushes.
    if (!reset) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_sel_mem  = 1'b0;
      count_flush = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics and watchdog
  // ---------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = '0;

    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (count_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;

    if (!pc_en)
      consec_d = (consec_q >= CONSEC_MAX) ? consec_q : consec_q + 1'b1;

    wdog_d = wdog_q | (consec_d >= CONSEC_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      consec_q    <= '0;
      wdog_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pc_sel_mem  = pc_sel_mem;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.wdog_err    = wdog_q;

endmodule
